tiger_decode_regs: RTL

//  Parametrised decode-stage register/CP0 unit: multi-port writeback register file, CP0
//  (cause/status/epc/cache-ctl) with edge-latched, maskable, prioritised interrupts, and the

---
 rtl/tiger_decode_regs_if.sv | 35 +++
 rtl/tiger_decode_regs.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/tiger_decode_regs_if.sv
// Decode-stage bus for tiger_decode_regs: decode inputs, writeback ports, interrupt lines
// and the Decode->Execute pipeline outputs.
interface tiger_decode_regs_if #(
    parameter int DATA_W  = 32,
    parameter int NUM_WB  = 2,
    parameter int NUM_IRQ = 6
);
    logic                       stall;
    logic                       clear;
    logic [NUM_IRQ-1:0]         irq;
    logic [31:0]                instr;
    logic [DATA_W-1:0]          pcDe;
    logic                       bdDe;
    logic [NUM_WB-1:0]          wbEn;
    logic                       wbCopEn;
    logic [5*NUM_WB-1:0]        wbNum;
    logic [DATA_W*NUM_WB-1:0]   wbData;
    logic                       exception;
    logic                       iCacheFlush;
    logic                       dCacheFlush;
    logic [31:0]                instrEx;
    logic [DATA_W-1:0]          rsEx;
    logic [DATA_W-1:0]          rtEx;
    logic [DATA_W-1:0]          CPOutEx;

    modport master (
        output stall, clear, irq, instr, pcDe, bdDe, wbEn, wbCopEn, wbNum, wbData,
        input  exception, iCacheFlush, dCacheFlush, instrEx, rsEx, rtEx, CPOutEx
    );

    modport slave (
        input  stall, clear, irq, instr, pcDe, bdDe, wbEn, wbCopEn, wbNum, wbData,
        output exception, iCacheFlush, dCacheFlush, instrEx, rsEx, rtEx, CPOutEx
    );
endinterface

// File: rtl/tiger_decode_regs.sv
// Decode-stage register file, CP0 (cause/status/epc/cache-ctl) with edge-latched interrupts,
// and the Decode->Execute pipeline register. Define TIGER_DECODE_WB_BYPASS_EN for same-cycle
// writeback-to-read forwarding.
module tiger_decode_regs #(
    parameter int               DATA_W  = 32,
    parameter int               NREGS   = 32,
    parameter int               NUM_WB  = 2,
    parameter int               NUM_IRQ = 6,
    parameter int               SP_REG  = 29,
    parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(32'h0078_0000)
) (
    input logic               clk,
    input logic               reset,
    tiger_decode_regs_if.slave bus
);
    typedef enum logic [1:0] {EXC_NONE, EXC_IRQ, EXC_BREAK, EXC_SYSCALL} exc_e;

    localparam logic [4:0]        SP_IDX     = 5'(SP_REG);
    localparam logic [31:0]       ERET_INSTR = 32'h4200_0018;
    localparam logic [DATA_W-1:0] STATUS_RST =
        {{(DATA_W-8-NUM_IRQ){1'b0}}, {NUM_IRQ{1'b1}}, 8'h00};

    logic [DATA_W-1:0]  rf_q [NREGS];
    logic [DATA_W-1:0]  cause_q, cause_d, status_q, status_d, epc_q, epc_d;
    logic [NUM_IRQ-1:0] irq_hist_q, pending_q, pending_d;
    logic [NUM_IRQ-1:0] irq_edge, irq_masked, irq_onehot, irq_accept;
    logic               iflush_q, iflush_d, dflush_q, dflush_d;
    logic [31:0]        instr_ex_q, instr_ex_d;
    logic [DATA_W-1:0]  rs_ex_q, rs_ex_d, rt_ex_q, rt_ex_d, cp_ex_q, cp_ex_d;

    logic [4:0]         rs_num, rt_num, cp_sel, cop_num;
    logic [DATA_W-1:0]  cop_data, rs_val, rt_val, cp_val;
    logic               is_syscall, is_break, is_eret, irq_req, exception, commit, no_hold;
    exc_e               exc_kind;
    logic [3:0]         exc_code;

    assign rs_num   = bus.instr[25:21];
    assign rt_num   = bus.instr[20:16];
    assign cp_sel   = bus.instr[15:11];
    assign cop_num  = bus.wbNum[4:0];
    assign cop_data = bus.wbData[DATA_W-1:0];

    assign is_syscall = (bus.instr[31:26] == 6'd0) && (bus.instr[5:0] == 6'h0C);
    assign is_break   = (bus.instr[31:26] == 6'd0) && (bus.instr[5:0] == 6'h0D);
    assign is_eret    = (bus.instr == ERET_INSTR);

    // Interrupts latch on a rising edge and stay pending until that line is accepted.
    assign irq_edge   = bus.irq & ~irq_hist_q;
    assign irq_masked = pending_q & status_q[8 +: NUM_IRQ];
    assign irq_onehot = irq_masked & (~irq_masked + NUM_IRQ'(1));
    assign irq_req    = !status_q[0] && (|irq_masked);

    assign exception = irq_req || is_break || is_syscall;
    assign no_hold   = !bus.stall && !bus.clear;
    assign commit    = exception && no_hold;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        exc_kind = EXC_NONE;
        exc_code = 4'd0;
        if (irq_req) begin
            exc_kind = EXC_IRQ;
        end else if (is_break) begin
            exc_kind = EXC_BREAK;
            exc_code = 4'd9;
        end else if (is_syscall) begin
            exc_kind = EXC_SYSCALL;
            exc_code = 4'd8;
        end
    end

    assign irq_accept = (commit && exc_kind == EXC_IRQ) ? irq_onehot : '0;
    assign pending_d  = (pending_q & ~irq_accept) | irq_edge;

    always_comb begin
        rs_val = rf_q[rs_num];
        rt_val = rf_q[rt_num];
`ifdef TIGER_DECODE_WB_BYPASS_EN
        // Later ports overwrite earlier ones, matching the register-file collision rule.
        for (int i = 0; i < NUM_WB; i++) begin
            if (bus.wbEn[i] && bus.wbNum[5*i +: 5] == rs_num) rs_val = bus.wbData[DATA_W*i +: DATA_W];
            if (bus.wbEn[i] && bus.wbNum[5*i +: 5] == rt_num) rt_val = bus.wbData[DATA_W*i +: DATA_W];
        end
`endif
        if (rs_num == 5'd0) rs_val = '0;
        if (rt_num == 5'd0) rt_val = '0;
    end

    always_comb begin
        case (cp_sel)
            5'd0:    cp_val = cause_q;
            5'd1:    cp_val = status_q;
            5'd2:    cp_val = epc_q;
            default: cp_val = '0;
        endcase
    end

    always_comb begin
        cause_d  = cause_q;
        status_d = status_q;
        epc_d    = epc_q;
        iflush_d = 1'b0;
        dflush_d = 1'b0;
        if (bus.wbCopEn) begin
            case (cop_num)
                5'd0:    cause_d  = cop_data;
                5'd1:    status_d = cop_data;
                5'd2:    epc_d    = cop_data;
                5'd3: begin
                    iflush_d = cop_data[0];
                    dflush_d = cop_data[1];
                end
                default: ;
            endcase
        end
        if (is_eret && no_hold) status_d[0] = 1'b0;
        // A committing exception discards any same-cycle CP0 write to cause/status/epc.
        if (commit) begin
            cause_d             = '0;
            cause_d[DATA_W-1]   = bus.bdDe;
            cause_d[5:2]        = exc_code;
            if (exc_kind == EXC_IRQ) cause_d[8 +: NUM_IRQ] = irq_onehot;
            epc_d               = bus.pcDe;
            status_d            = status_q;
            status_d[0]         = 1'b1;
        end
    end

    always_comb begin
        instr_ex_d = instr_ex_q;
        rs_ex_d    = rs_ex_q;
        rt_ex_d    = rt_ex_q;
        cp_ex_d    = cp_ex_q;
        if (!bus.stall) begin
            if (bus.clear || commit) begin
                instr_ex_d = '0;
                rs_ex_d    = '0;
                rt_ex_d    = '0;
                cp_ex_d    = '0;
            end else begin
                instr_ex_d = bus.instr;
                rs_ex_d    = rs_val;
                rt_ex_d    = rt_val;
                cp_ex_d    = cp_val;
            end
        end
    end

    // NOTE: only the stack pointer has a reset value; other GPRs keep their contents.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rf_q[SP_IDX] <= SP_INIT;
        end else begin
            for (int i = 0; i < NUM_WB; i++) begin
                if (bus.wbEn[i] && bus.wbNum[5*i +: 5] != 5'd0)
                    rf_q[bus.wbNum[5*i +: 5]] <= bus.wbData[DATA_W*i +: DATA_W];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cause_q    <= '0;
            status_q   <= STATUS_RST;
            epc_q      <= '0;
            pending_q  <= '0;
            irq_hist_q <= '0;
            iflush_q   <= 1'b0;
            dflush_q   <= 1'b0;
            instr_ex_q <= '0;
            rs_ex_q    <= '0;
            rt_ex_q    <= '0;
            cp_ex_q    <= '0;
        end else begin
            cause_q    <= cause_d;
            status_q   <= status_d;
            epc_q      <= epc_d;
            pending_q  <= pending_d;
            irq_hist_q <= bus.irq;
            iflush_q   <= iflush_d;
            dflush_q   <= dflush_d;
            instr_ex_q <= instr_ex_d;
            rs_ex_q    <= rs_ex_d;
            rt_ex_q    <= rt_ex_d;
            cp_ex_q    <= cp_ex_d;
        end
    end

    assign bus.exception   = exception;
    assign bus.iCacheFlush = iflush_q;
    assign bus.dCacheFlush = dflush_q;
    assign bus.instrEx     = instr_ex_q;
    assign bus.rsEx        = rs_ex_q;
    assign bus.rtEx        = rt_ex_q;
    assign bus.CPOutEx     = cp_ex_q;
endmodule
